prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 193 +++++++++++++++++++
 tb/tb_prog_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Purpose:
//    Receives a framed program image over a byte-serial link and writes it into
//    a 16x8 register program memory. The CPU fetches from this memory
//    combinationally. Frame layout:
//       0xA5, L, L data bytes, checksum (8-bit sum of the data bytes)
//    A good frame ends in DONE, where the CPU may run. A bad length or a bad
//    checksum ends in ERROR. A rising edge on load_en starts a new load. Taking
//    load_en low while a frame is in progress aborts the load.
//
// Ports:
//    clk        - rising-edge clock for all state
//    rst        - synchronous active-high reset (also clears the memory)
//    load_en    - load request; rise starts a load, low level aborts one
//    byte_in    - serial program byte
//    byte_valid - byte_in carries a byte this cycle
//    byte_ready - loader accepts a byte this cycle (Moore)
//    rd_addr    - CPU fetch address
//    rd_instr   - program word at rd_addr (combinational)
//    cpu_run    - program image valid, CPU may execute
//    load_err   - last load failed
//    prog_len   - word count of the last successful load
// ---------------------------------------------------------------------------
module prog_loader (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_en,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_instr,
   output logic       cpu_run,
   output logic       load_err,
   output logic [4:0] prog_len
);

   localparam logic [7:0] HeaderByte = 8'hA5;
   localparam logic [7:0] MaxLen     = 8'd16;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LEN,
      DATA,
      CSUM,
      DONE,
      ERROR
   } state_e;

   state_e     state_q, state_d;
   logic       loadEn_q;
   logic [4:0] cnt_q, cnt_d;
   logic [7:0] sum_q, sum_d;
   logic [4:0] len_q, len_d;
   logic [4:0] progLen_q, progLen_d;
   logic [7:0] mem_q [16];

   logic       loadRise;
   logic       xfer;
   logic       lenLegal;
   logic       lastData;
   logic       memWe;
   logic [3:0] memWAddr;
   logic [7:0] memWData;

   // A byte moves only when both sides agree. Because byte_ready is Moore,
   // xfer depends on the current state and the two inputs only.
   assign loadRise = load_en & ~loadEn_q;
   assign xfer     = byte_valid & byte_ready;
   assign lenLegal = (byte_in != 8'd0) && (byte_in <= MaxLen);
   assign lastData = (cnt_q == (len_q - 5'd1));

   // State register plus the load_en history used for rise detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         loadEn_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         loadEn_q <= load_en;
      end
   end

   // Next-state logic. In the four receiving states a low load_en wins over
   // any byte that is offered on the same edge. DONE and ERROR ignore a low
   // load_en, so the result stays visible until the next load request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (loadRise) state_d = HDR;
         end
         HDR: begin
            if (!load_en)                          state_d = IDLE;
            else if (xfer && byte_in == HeaderByte) state_d = LEN;
         end
         LEN: begin
            if (!load_en)  state_d = IDLE;
            else if (xfer) state_d = lenLegal ? DATA : ERROR;
         end
         DATA: begin
            if (!load_en)              state_d = IDLE;
            else if (xfer && lastData) state_d = CSUM;
         end
         CSUM: begin
            if (!load_en)  state_d = IDLE;
            else if (xfer) state_d = (byte_in == sum_q) ? DONE : ERROR;
         end
         DONE, ERROR: begin
            if (loadRise) state_d = HDR;
         end
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs decoded from the current state only.
   always_comb begin
      byte_ready = 1'b0;
      cpu_run    = 1'b0;
      load_err   = 1'b0;
      case (state_q)
         HDR, LEN, DATA, CSUM: byte_ready = 1'b1;
         DONE:                 cpu_run    = 1'b1;
         ERROR:                load_err   = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: length latch, word counter, running checksum,
   // committed length and the single memory write port. Every update is
   // gated by load_en so that an abort on the same edge writes nothing.
   // cnt never passes 15 while a write can occur, because DATA is left on
   // the transfer where cnt equals L-1.
   always_comb begin
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      len_d     = len_q;
      progLen_d = progLen_q;
      memWe     = 1'b0;
      memWAddr  = cnt_q[3:0];
      memWData  = byte_in;
      if (xfer && load_en) begin
         case (state_q)
            LEN: begin
               if (lenLegal) begin
                  len_d = byte_in[4:0];
                  cnt_d = 5'd0;
                  sum_d = 8'd0;
               end
            end
            DATA: begin
               memWe = 1'b1;
               cnt_d = cnt_q + 5'd1;
               sum_d = sum_q + byte_in;
            end
            CSUM: begin
               if (byte_in == sum_q) progLen_d = len_q;
            end
            default: ;
         endcase
      end
   end

   // Datapath registers and program memory. Reset clears every word, while
   // a new load does not: words past the new length keep their old contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= 5'd0;
         sum_q     <= 8'd0;
         len_q     <= 5'd0;
         progLen_q <= 5'd0;
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         len_q     <= len_d;
         progLen_q <= progLen_d;
         if (memWe) begin
            mem_q[memWAddr] <= memWData;
         end
      end
   end

   // CPU fetch port: a plain combinational read of the register file.
   assign rd_instr = mem_q[rd_addr];
   assign prog_len = progLen_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Directed testbench for prog_loader. Inputs change 1 time unit after each
// rising edge, and outputs are sampled at that same point. The memory is read
// back through rd_addr in 1-unit steps, which stay well inside the 50-unit
// half period.
// ---------------------------------------------------------------------------
module tb_prog_loader;

   logic       clk;
   logic       rst;
   logic       load_en;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;
   logic [3:0] rd_addr;
   logic [7:0] rd_instr;
   logic       cpu_run;
   logic       load_err;
   logic [4:0] prog_len;

   int checks;
   int errors;

   prog_loader dut (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .rd_addr    (rd_addr),
      .rd_instr   (rd_instr),
      .cpu_run    (cpu_run),
      .load_err   (load_err),
      .prog_len   (prog_len)
   );

   // 100-unit clock period.
   initial clk = 1'b0;
   always #50 clk = ~clk;

   // Single point of comparison: count it, report a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read one memory word through the CPU fetch port.
   task automatic checkMem(input int addr, input logic [7:0] expected);
      rd_addr = addr[3:0];
      #1;
      checkOutput($sformatf("mem[%0d]", addr), {24'd0, rd_instr}, {24'd0, expected});
   endtask

   // Create a load_en rise. From DONE or ERROR the low cycle leaves the
   // state unchanged. After the high cycle the loader sits in HDR.
   task automatic applyStimulus();
      load_en = 1'b0;
      tick();
      load_en = 1'b1;
      tick();
   endtask

   // Offer one byte and hold it until the loader takes it. The wait is
   // bounded, and running out of cycles counts as a failure.
   task automatic sendByte(input logic [7:0] b);
      int waited;
      waited     = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (byte_ready !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      if (waited >= 20) begin
         checkOutput("ready_timeout", 32'd0, 32'd1);
      end else begin
         tick();
      end
      byte_valid = 1'b0;
   endtask

   // Insert a random number of empty cycles with garbage on byte_in.
   task automatic idleGap();
      int n;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
         byte_valid = 1'b0;
         byte_in    = 8'($urandom);
         tick();
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      load_en    = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      rd_addr    = 4'd0;

      // Reset state.
      tick();
      tick();
      rst = 1'b0;
      checkOutput("rst_ready", {31'd0, byte_ready}, 32'd0);
      checkOutput("rst_run", {31'd0, cpu_run}, 32'd0);
      checkOutput("rst_err", {31'd0, load_err}, 32'd0);
      checkOutput("rst_len", {27'd0, prog_len}, 32'd0);
      checkMem(0, 8'h00);
      checkMem(9, 8'h00);
      checkMem(15, 8'h00);
      tick();
      checkOutput("idle_ready", {31'd0, byte_ready}, 32'd0);

      // Good load: 13+21+60 = 94.
      applyStimulus();
      checkOutput("hdr_ready", {31'd0, byte_ready}, 32'd1);
      sendByte(8'hA5);
      sendByte(8'h03);
      sendByte(8'h13);
      sendByte(8'h21);
      sendByte(8'h60);
      sendByte(8'h94);
      checkOutput("good_run", {31'd0, cpu_run}, 32'd1);
      checkOutput("good_err", {31'd0, load_err}, 32'd0);
      checkOutput("good_len", {27'd0, prog_len}, 32'd3);
      checkOutput("good_ready", {31'd0, byte_ready}, 32'd0);
      checkMem(0, 8'h13);
      checkMem(1, 8'h21);
      checkMem(2, 8'h60);
      checkMem(3, 8'h00);

      // DONE does not accept bytes and stays in DONE.
      byte_valid = 1'b1;
      byte_in    = 8'hA5;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("done_noaccept", {31'd0, byte_ready}, 32'd0);
      end
      checkOutput("done_hold", {31'd0, cpu_run}, 32'd1);
      byte_valid = 1'b0;

      // Bad checksum: 95 instead of 94.
      applyStimulus();
      checkOutput("reload_run", {31'd0, cpu_run}, 32'd0);
      sendByte(8'hA5);
      sendByte(8'h03);
      sendByte(8'h13);
      sendByte(8'h21);
      sendByte(8'h60);
      sendByte(8'h95);
      checkOutput("bad_err", {31'd0, load_err}, 32'd1);
      checkOutput("bad_run", {31'd0, cpu_run}, 32'd0);
      checkOutput("bad_len", {27'd0, prog_len}, 32'd3);
      checkOutput("bad_ready", {31'd0, byte_ready}, 32'd0);
      checkMem(2, 8'h60);

      // Header hunt, then the L=16 boundary: sum of 0..15 = 0x78.
      applyStimulus();
      checkOutput("hunt_errclr", {31'd0, load_err}, 32'd0);
      sendByte(8'h00);
      sendByte(8'hFF);
      sendByte(8'hA5);
      sendByte(8'h10);
      for (int i = 0; i < 16; i++) sendByte(8'(i));
      sendByte(8'h78);
      checkOutput("l16_run", {31'd0, cpu_run}, 32'd1);
      checkOutput("l16_len", {27'd0, prog_len}, 32'd16);
      for (int i = 0; i < 16; i++) checkMem(i, 8'(i));

      // An out-of-range length (L=17) and a zero length both fail.
      applyStimulus();
      sendByte(8'hA5);
      sendByte(8'h11);
      checkOutput("l17_err", {31'd0, load_err}, 32'd1);
      applyStimulus();
      sendByte(8'hA5);
      sendByte(8'h00);
      checkOutput("l0_err", {31'd0, load_err}, 32'd1);
      checkOutput("l0_len", {27'd0, prog_len}, 32'd16);

      // A short load keeps the old contents above its length.
      applyStimulus();
      sendByte(8'hA5);
      sendByte(8'h03);
      sendByte(8'h13);
      sendByte(8'h21);
      sendByte(8'h60);
      sendByte(8'h94);
      checkOutput("short_len", {27'd0, prog_len}, 32'd3);
      checkMem(0, 8'h13);
      checkMem(3, 8'h03);
      checkMem(15, 8'h0F);

      // Abort after two data bytes. The byte offered on the abort edge must
      // not be written, so mem[2] keeps 60.
      applyStimulus();
      sendByte(8'hA5);
      sendByte(8'h03);
      sendByte(8'hAA);
      sendByte(8'hBB);
      load_en    = 1'b0;
      byte_valid = 1'b1;
      byte_in    = 8'hCC;
      tick();
      byte_valid = 1'b0;
      checkOutput("abort_ready", {31'd0, byte_ready}, 32'd0);
      checkOutput("abort_run", {31'd0, cpu_run}, 32'd0);
      checkOutput("abort_err", {31'd0, load_err}, 32'd0);
      checkMem(0, 8'hAA);
      checkMem(1, 8'hBB);
      checkMem(2, 8'h60);

      // IDLE does not accept bytes.
      byte_valid = 1'b1;
      tick();
      checkOutput("idle_noaccept", {31'd0, byte_ready}, 32'd0);
      byte_valid = 1'b0;

      // Reload after the abort: 5 words with random gaps, 11+22+33+44+55 = FF.
      applyStimulus();
      idleGap();
      sendByte(8'hA5);
      idleGap();
      sendByte(8'h05);
      for (int i = 1; i <= 5; i++) begin
         idleGap();
         sendByte(8'(i * 8'h11));
      end
      idleGap();
      sendByte(8'hFF);
      checkOutput("gap_run", {31'd0, cpu_run}, 32'd1);
      checkOutput("gap_len", {27'd0, prog_len}, 32'd5);
      for (int i = 0; i < 5; i++) checkMem(i, 8'((i + 1) * 8'h11));
      checkMem(5, 8'h05);

      // Reset in the middle of DATA clears everything.
      applyStimulus();
      sendByte(8'hA5);
      sendByte(8'h05);
      sendByte(8'h11);
      rst        = 1'b1;
      load_en    = 1'b0;
      byte_valid = 1'b1;
      byte_in    = 8'h22;
      tick();
      rst        = 1'b0;
      byte_valid = 1'b0;
      checkOutput("mrst_ready", {31'd0, byte_ready}, 32'd0);
      checkOutput("mrst_run", {31'd0, cpu_run}, 32'd0);
      checkOutput("mrst_err", {31'd0, load_err}, 32'd0);
      checkOutput("mrst_len", {27'd0, prog_len}, 32'd0);
      for (int i = 0; i < 16; i++) checkMem(i, 8'h00);
      tick();
      checkOutput("mrst_ready2", {31'd0, byte_ready}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
